// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a bouncing raw input, qualifies level changes over
// STABLE_SAMPLES sample ticks, and emits a clean level plus press/release strobes.
module button_debouncer #(
    parameter int STABLE_SAMPLES = 4,
    parameter int COUNT_BITS     = 3,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic inputCLK,
    input  logic reset,
    input  logic sampleCLK,
    input  logic buttonIn,
    output logic buttonLevel,
    output logic pressPulse,
    output logic releasePulse,
    output logic busy
);
    typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_t;

    localparam logic [COUNT_BITS-1:0] LAST = COUNT_BITS'(STABLE_SAMPLES - 1);

    state_t                state, state_n;
    logic [COUNT_BITS-1:0] count, count_n;
    logic                  sync1, sync2, sample_d;
    logic                  btn_s, tick, at_last;
    logic                  press_n, release_n;

    assign btn_s   = sync2 ^ ACTIVE_LOW;
    assign tick    = sampleCLK & ~sample_d;
    assign at_last = count == LAST;

    // Sync flops reset to the idle polarity so the corrected sample starts inactive.
    always_ff @(posedge inputCLK or posedge reset) begin
        if (reset) begin
            sync1    <= ACTIVE_LOW;
            sync2    <= ACTIVE_LOW;
            sample_d <= 1'b0;
        end else begin
            sync1    <= buttonIn;
            sync2    <= sync1;
            sample_d <= sampleCLK;
        end
    end

    always_ff @(posedge inputCLK or posedge reset) begin
        if (reset) begin
            state        <= LOW;
            count        <= '0;
            buttonLevel  <= 1'b0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            buttonLevel  <= state_n == HIGH || state_n == CHK_LOW;
            pressPulse   <= press_n;
            releasePulse <= release_n;
            busy         <= state_n == CHK_HIGH || state_n == CHK_LOW;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        press_n   = 1'b0;
        release_n = 1'b0;
        if (tick) begin
            case (state)
                LOW: if (btn_s) begin
                    state_n = CHK_HIGH;
                    count_n = COUNT_BITS'(1);
                end
                CHK_HIGH: begin
                    state_n = !btn_s ? LOW : at_last ? HIGH : CHK_HIGH;
                    count_n = (btn_s && !at_last) ? count + 1'b1 : '0;
                    press_n = btn_s && at_last;
                end
                HIGH: if (!btn_s) begin
                    state_n = CHK_LOW;
                    count_n = COUNT_BITS'(1);
                end
                CHK_LOW: begin
                    state_n   = btn_s ? HIGH : at_last ? LOW : CHK_LOW;
                    count_n   = (!btn_s && !at_last) ? count + 1'b1 : '0;
                    release_n = !btn_s && at_last;
                end
                default: begin
                    state_n = LOW;
                    count_n = '0;
                end
            endcase
        end
    end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Debounces one raw mechanical input (push-button or switch) and produces a clean level plus single-cycle press and release strobes. It is the stage directly downstream of the frequency divider. The divider's slow output is the sample strobe, so the debounce window is set by the divider ratio times STABLE_SAMPLES. All logic runs in the inputCLK domain. The slow clock is only edge-detected, never used as a clock.

Parameters:
STABLE_SAMPLES, 4, number of consecutive identical samples needed to accept a new level; legal range >= 2.
COUNT_BITS, 3, width of the sample counter; must hold STABLE_SAMPLES-1.
ACTIVE_LOW, 0, 1 = raw input is active-low; it is inverted after synchronization.

Ports:
inputCLK  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high; clears all state.
sampleCLK  input  1  slow clock from the frequency divider; each rising edge is one sample request.
buttonIn  input  1  raw, asynchronous, bouncing input.
buttonLevel  output  1  debounced level, active-high after polarity correction.
pressPulse  output  1  high exactly one inputCLK cycle when buttonLevel goes 0->1.
releasePulse  output  1  high exactly one inputCLK cycle when buttonLevel goes 1->0.
busy  output  1  high while a candidate level change is being qualified (CHK states).

Behaviour:
- Reset (async, active-high):
  - State = LOW, counter = 0.
  - buttonLevel, pressPulse, releasePulse, busy = 0.
  - sampleCLK edge-detect register = 0.
  - Sync flops reset to ACTIVE_LOW, so the corrected sample btnS = 0.
- Synchronizer: buttonIn passes through 2 flops. btnS = sync2 XOR ACTIVE_LOW. Synchronizer latency is 2 inputCLK cycles.
- Tick: tick = sampleCLK AND NOT sampleCLK_d. It is one inputCLK cycle per sampleCLK rising edge. sampleCLK held high yields exactly one tick.
- The FSM and counter change only on cycles where tick = 1. Otherwise all state holds.
- States and transitions:
  - LOW: btnS=1 -> CHK_HIGH, counter=1. Otherwise stay.
  - CHK_HIGH, btnS=1 and counter==STABLE_SAMPLES-1 -> HIGH, counter=0, buttonLevel<=1, pressPulse<=1.
  - CHK_HIGH, btnS=1, otherwise -> counter+1.
  - CHK_HIGH, btnS=0 -> LOW, counter=0, no pulse.
  - HIGH: btnS=0 -> CHK_LOW, counter=1. Otherwise stay.
  - CHK_LOW, btnS=0 and counter==STABLE_SAMPLES-1 -> LOW, counter=0, buttonLevel<=0, releasePulse<=1.
  - CHK_LOW, btnS=0, otherwise -> counter+1.
  - CHK_LOW, btnS=1 -> HIGH, counter=0, no pulse.
- Outputs:
  - All outputs are registered.
  - pressPulse and releasePulse assert in the same cycle buttonLevel changes and clear on the next cycle.
  - Press and release can never be high together.
  - busy = 1 exactly while state is CHK_HIGH or CHK_LOW.
- Latency: buttonLevel changes at the inputCLK edge ending the cycle of the STABLE_SAMPLES-th consecutive qualifying tick. The first qualifying tick is the first tick at least 2 cycles after buttonIn settles.
- Reset mid-operation:
  - Outputs drop to 0 immediately and any qualification in progress is discarded.
  - An input held active through reset must re-qualify with a full STABLE_SAMPLES ticks before pressPulse.
- Counter: never exceeds STABLE_SAMPLES-1, with no wrap-around. Out-of-range parameters are illegal and need no defined behaviour.

Test Plan:
Common setup: divider ratio 10 (tick every 10 cycles), STABLE_SAMPLES=4, ACTIVE_LOW=0 unless stated.
- Reset, then buttonIn=0 for 200 cycles -> buttonLevel, pressPulse, releasePulse and busy all stay 0.
- buttonIn 0->1 and held -> busy rises at the first tick. After 4 ticks (32-42 cycles after the input edge) buttonLevel=1 with exactly one pressPulse cycle in the same cycle; releasePulse stays 0.
- Bounce: buttonIn high for 2 ticks, low for 1 tick, repeated 5 times -> no pressPulse, buttonLevel stays 0, busy pulses each burst then returns to 0.
- From a stable HIGH, buttonIn 1->0 held -> after 4 ticks buttonLevel=0 with exactly one releasePulse. A single-tick glitch to 1 during CHK_LOW returns to HIGH with no pulses.
- Reset asserted in CHK_HIGH at counter=2 with buttonIn held 1 -> busy drops to 0 asynchronously. After reset release, pressPulse occurs only after 4 fresh ticks.
- sampleCLK tied high for 100 cycles with buttonIn=1 -> counter advances once only (busy=1, no press). ACTIVE_LOW=1 with buttonIn driven 0 for 4 ticks -> pressPulse and buttonLevel=1.
